// File: rtl/neptune_tone_gen.sv
// Reference-pitch square-wave generator with ready/load setting handshake; settings apply at period boundaries.
// Optional glide (cur steps by 1 per period toward target) is enabled by defining NEPTUNE_TONE_GLIDE_EN.
`timescale 1ns/1ps
module neptune_tone_gen #(
  parameter int CNT_W        = 12,
  parameter int DETUNE_SHIFT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] clk_config_i,
  input  logic [2:0] note_sel_i,
  input  logic [1:0] detune_i,
  input  logic       load_i,
  output logic       ready_o,
  output logic       pulse_out_o,
  output logic       period_strobe_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_q;
  logic [2:0]       presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cur_q;
  logic [CNT_W-1:0] tgt_q;
  logic             pend_off_q;
  logic             ready_q;
  logic             pulse_q;
  logic             strobe_q;

  logic [2:0]       presc_lim;
  logic             tick;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] tgt_calc;
  logic             off_calc;
  logic [CNT_W-1:0] cur_next;

  always_comb begin
    base = '0;
    case (note_sel_i)
      3'd0:    base = CNT_W'(607);
      3'd1:    base = CNT_W'(455);
      3'd2:    base = CNT_W'(341);
      3'd3:    base = CNT_W'(255);
      3'd4:    base = CNT_W'(202);
      3'd5:    base = CNT_W'(152);
      default: base = '0;
    endcase
    case (detune_i)
      2'b01:   tgt_calc = base - (base >> DETUNE_SHIFT);
      2'b10:   tgt_calc = base + (base >> DETUNE_SHIFT);
      default: tgt_calc = base;
    endcase
    off_calc = (note_sel_i >= 3'd6) || (detune_i == 2'b11);
  end

  always_comb begin
    presc_lim = 3'd0;
    case (clk_config_i)
      2'd0: presc_lim = 3'd0;
      2'd1: presc_lim = 3'd1;
      2'd2: presc_lim = 3'd3;
      2'd3: presc_lim = 3'd7;
      default: presc_lim = 3'd0;
    endcase
    tick = (presc_q == presc_lim);
  end

`ifdef NEPTUNE_TONE_GLIDE_EN
  always_comb begin
    if (cur_q < tgt_q)      cur_next = cur_q + 1'b1;
    else if (cur_q > tgt_q) cur_next = cur_q - 1'b1;
    else                    cur_next = cur_q;
  end
`else
  assign cur_next = tgt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      cur_q      <= '0;
      tgt_q      <= '0;
      pend_off_q <= 1'b1;
      ready_q    <= 1'b1;
      pulse_q    <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      presc_q  <= tick ? 3'd0 : presc_q + 3'd1;
      if (tick) begin
        case (state_q)
          IDLE: begin
            ready_q <= 1'b1;
            if (!pend_off_q) begin
              cur_q    <= tgt_q;
              cnt_q    <= tgt_q - 1'b1;
              state_q  <= HIGH;
              pulse_q  <= 1'b1;
              strobe_q <= 1'b1;
            end
          end
          HIGH: begin
            if (cnt_q == '0) begin
              state_q <= LOW;
              pulse_q <= 1'b0;
              cnt_q   <= cur_q - 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          LOW: begin
            if (cnt_q == '0) begin
              // Period boundary: the only point where a pending setting is adopted.
              if (pend_off_q) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                ready_q <= 1'b1;
              end else begin
                cur_q    <= cur_next;
                cnt_q    <= cur_next - 1'b1;
                state_q  <= HIGH;
                pulse_q  <= 1'b1;
                strobe_q <= 1'b1;
                ready_q  <= (cur_next == tgt_q);
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // A load is accepted only while ready; it overrides any ready set above.
      if (load_i && ready_q) begin
        tgt_q      <= tgt_calc;
        pend_off_q <= off_calc;
        ready_q    <= 1'b0;
      end
    end
  end

  assign ready_o         = ready_q;
  assign pulse_out_o     = pulse_q;
  assign period_strobe_o = strobe_q;

endmodule

// File: tb/tb_neptune_tone_gen.sv
// Scoreboard bench for neptune_tone_gen: stimulus queues expected high/low phase lengths, a monitor measures and compares.
`timescale 1ns/1ps
module tb_neptune_tone_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] clk_config = 2'd0;
  logic [2:0] note_sel = 3'd0;
  logic [1:0] detune = 2'd0;
  logic       load = 1'b0;
  logic       ready, pulse_out, period_strobe;

  int total = 0;
  int bad = 0;
  int exp_hi[$];
  int exp_lo[$];
  int skip_req = 0;
  int disarm_req = 0;

  neptune_tone_gen dut (
    .clk(clk), .rst(rst), .clk_config_i(clk_config), .note_sel_i(note_sel),
    .detune_i(detune), .load_i(load), .ready_o(ready), .pulse_out_o(pulse_out),
    .period_strobe_o(period_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #(700_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: measures each phase length in clk cycles and pops the matching expectation.
  initial begin
    logic prev_p;
    int   run_len, e, skip_seen, disarm_seen;
    bit   lo_armed;
    prev_p = 1'b0; run_len = 0; lo_armed = 0; skip_seen = 0; disarm_seen = 0;
    forever begin
      @(negedge clk);
      if (disarm_req != disarm_seen) begin
        disarm_seen = disarm_req;
        lo_armed = 0;
      end
      if (pulse_out !== prev_p) begin
        if (prev_p == 1'b1) begin
          if (skip_req != skip_seen) begin
            skip_seen = skip_req;
            if (exp_hi.size() > 0) e = exp_hi.pop_front();
          end else begin
            total++;
            if (exp_hi.size() == 0) begin
              bad++;
              $display("FAIL hi_len: got %0d with no expectation queued", run_len);
            end else begin
              e = exp_hi.pop_front();
              if (run_len != e) begin
                bad++;
                $display("FAIL hi_len: got %0d expected %0d", run_len, e);
              end
            end
            lo_armed = 1;
          end
        end else begin
          total++;
          if (period_strobe !== 1'b1) begin
            bad++;
            $display("FAIL strobe_at_rise: got %0b expected 1", period_strobe);
          end
          total++;
          if (exp_hi.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rise: got rise, expected none");
          end
          if (lo_armed) begin
            total++;
            if (exp_lo.size() == 0) begin
              bad++;
              $display("FAIL lo_len: got %0d with no expectation queued", run_len);
            end else begin
              e = exp_lo.pop_front();
              if (run_len != e) begin
                bad++;
                $display("FAIL lo_len: got %0d expected %0d", run_len, e);
              end
            end
          end
          lo_armed = 0;
        end
        prev_p = pulse_out;
        run_len = 1;
      end else begin
        run_len++;
        if (period_strobe === 1'b1) begin
          total++; bad++;
          $display("FAIL strobe_no_rise: got strobe=1 with pulse_out=%0b steady", pulse_out);
        end
      end
    end
  end

  task automatic do_load(input logic [2:0] n, input logic [1:0] d);
    @(negedge clk);
    note_sel = n; detune = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_strobe !== 1'b1 && n < lim);
    check(name, int'(period_strobe === 1'b1), 1);
  endtask

  task automatic wait_fall(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pulse_out !== 1'b0 && n < lim);
    check("wait_fall", int'(pulse_out === 1'b0), 1);
  endtask

  task automatic wait_ready(input int lim, output int n);
    n = 0;
    while (ready !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic hold_quiet(input int cycles, output int rises);
    rises = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (pulse_out === 1'b1 || period_strobe === 1'b1) rises++;
    end
  endtask

  initial begin
    int n, q;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_pulse", int'(pulse_out), 0);
    check("reset_ready", int'(ready), 1);
    check("reset_strobe", int'(period_strobe), 0);

`ifndef NEPTUNE_TONE_GLIDE_EN
    // A2 exact from IDLE, then sharp, flat E2, D3, then off.
    exp_hi.push_back(455);
    do_load(3'd1, 2'b00);
    check("load_ready_low", int'(ready), 0);
    check("load_pulse_before", int'(pulse_out), 0);
    @(negedge clk);
    check("latency_pulse", int'(pulse_out), 1);
    check("latency_strobe", int'(period_strobe), 1);
    check("ready_after_rise", int'(ready), 1);
    exp_lo.push_back(455); exp_hi.push_back(455);
    wait_strobe("rise2_a2", 1000);
    check("ready_rise2", int'(ready), 1);
    do_load(3'd1, 2'b01);
    exp_lo.push_back(455); exp_hi.push_back(441);
    wait_strobe("rise3_a2s", 1000);
    check("ready_rise3", int'(ready), 1);
    do_load(3'd0, 2'b10);
    exp_lo.push_back(441); exp_hi.push_back(625);
    wait_strobe("rise4_e2f", 1000);
    check("ready_rise4", int'(ready), 1);
    do_load(3'd2, 2'b00);
    exp_lo.push_back(625); exp_hi.push_back(341);
    wait_strobe("rise5_d3", 1500);
    do_load(3'd2, 2'b11);
    wait_fall(500);
    wait_ready(1000, n);
    check("off_low_len", n, 341);
    disarm_req++;
    hold_quiet(1500, q);
    check("off_quiet", q, 0);
    check("off_ready", int'(ready), 1);
    check("q_empty_a", exp_hi.size() + exp_lo.size(), 0);

    // G3 exact with prescale /4; a second load while ready=0 must be ignored.
    @(negedge clk);
    clk_config = 2'd2;
    exp_hi.push_back(1020); exp_lo.push_back(1020); exp_hi.push_back(1020);
    do_load(3'd3, 2'b00);
    check("g3_ready_low", int'(ready), 0);
    note_sel = 3'd5; detune = 2'b00; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_strobe("rise1_g3", 20);
    wait_strobe("rise2_g3", 3000);
    do_load(3'd6, 2'b00);
    wait_fall(1500);
    wait_ready(3000, n);
    check("g3_off_low_len", n, 1020);
    disarm_req++;
    check("q_empty_b", exp_hi.size() + exp_lo.size(), 0);
`else
    // Glide from E4 to B3: half-period climbs 153..202, ready held low until 202.
    exp_hi.push_back(152);
    do_load(3'd5, 2'b00);
    wait_strobe("rise1_e4", 10);
    check("e4_ready", int'(ready), 1);
    do_load(3'd4, 2'b00);
    exp_lo.push_back(152);
    for (int v = 153; v <= 202; v++) exp_hi.push_back(v);
    for (int v = 153; v <= 201; v++) exp_lo.push_back(v);
    n = 0; q = 0;
    while (ready !== 1'b1 && q < 30000) begin
      @(negedge clk);
      q++;
      if (period_strobe === 1'b1) n++;
    end
    check("glide_periods_to_ready", n, 50);
    do_load(3'd6, 2'b00);
    wait_fall(500);
    wait_ready(1000, n);
    check("glide_off_low_len", n, 202);
    disarm_req++;
    check("q_empty_g", exp_hi.size() + exp_lo.size(), 0);
`endif

    // One-cycle reset mid-HIGH.
    @(negedge clk);
    clk_config = 2'd0;
    exp_hi.push_back(202);
    do_load(3'd4, 2'b00);
    wait_strobe("rise_b3", 10);
    repeat (50) @(negedge clk);
    skip_req++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_pulse", int'(pulse_out), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_strobe", int'(period_strobe), 0);
    hold_quiet(1000, q);
    check("rst_quiet", q, 0);
    disarm_req++;
    check("q_empty_end", exp_hi.size() + exp_lo.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
